// File: rtl/bsg_dff_chain_tap_en.sv
// Delay line of {valid, data} stages with stall, flush, a runtime output tap
// and a registered occupancy count. Zero stages collapses to a wire.
module bsg_dff_chain_tap_en #(
    parameter int unsigned width_p      = 27,
    parameter int unsigned max_stages_p = 4,
    parameter bit          gate_data_p  = 1'b0,
    localparam int unsigned tap_width_lp = (max_stages_p == 0) ? 1 : $clog2(max_stages_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    en_i,
    input  logic                    flush_i,
    input  logic                    v_i,
    input  logic [width_p-1:0]      data_i,
    input  logic [tap_width_lp-1:0] tap_i,
    output logic                    v_o,
    output logic [width_p-1:0]      data_o,
    output logic [tap_width_lp-1:0] cnt_o
);

    if (max_stages_p == 0) begin : g_wire
        assign v_o    = v_i;
        assign data_o = data_i;
        assign cnt_o  = '0;

        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, reset_i, en_i, flush_i, tap_i};
    end else begin : g_chain
        localparam int d_lp = int'(max_stages_p);

        logic [d_lp:1]             v_q, v_d;
        logic [width_p-1:0]        data_q [1:d_lp];
        logic [width_p-1:0]        data_d [1:d_lp];
        logic [tap_width_lp-1:0]   cnt_q, cnt_d;
        logic [tap_width_lp-1:0]   tap_clamped;

        // Stage 0 is the live input; stages 1..D are the registers.
        logic [d_lp:0]             v_s;
        logic [width_p-1:0]        data_s [0:d_lp];

        assign v_s = {v_q, v_i};

        always_comb begin
            data_s[0] = data_i;
            for (int k = 1; k <= d_lp; k++) begin
                data_s[k] = data_q[k];
            end
        end

        // Flush beats advance; stall holds everything.
        always_comb begin
            v_d    = v_q;
            data_d = data_q;
            cnt_d  = cnt_q;
            if (flush_i) begin
                v_d   = '0;
                cnt_d = '0;
            end else if (en_i) begin
                v_d = v_s[d_lp-1:0];
                for (int k = 1; k <= d_lp; k++) begin
                    if (!gate_data_p || v_s[k-1]) begin
                        data_d[k] = data_s[k-1];
                    end
                end
                cnt_d = cnt_q + tap_width_lp'(v_i) - tap_width_lp'(v_q[d_lp]);
            end
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                v_q   <= '0;
                cnt_q <= '0;
                for (int k = 1; k <= d_lp; k++) begin
                    data_q[k] <= '0;
                end
            end else begin
                v_q    <= v_d;
                data_q <= data_d;
                cnt_q  <= cnt_d;
            end
        end

        always_comb begin
            tap_clamped = (tap_i > tap_width_lp'(d_lp)) ? tap_width_lp'(d_lp) : tap_i;
            v_o         = v_s[tap_clamped];
            data_o      = data_s[tap_clamped];
        end

        assign cnt_o = cnt_q;
    end

endmodule

// File: tb/tb_bsg_dff_chain_tap_en.sv
// Bench for bsg_dff_chain_tap_en: D=4, D=3, D=4 gated and D=0 instances share
// stimulus and are checked against an array-of-stages reference model.
module tb_bsg_dff_chain_tap_en;
    localparam int W = 27;

    logic clk = 1'b0;
    logic reset_i, en_i, flush_i, v_i;
    logic [W-1:0] data_i;
    logic [2:0] tap4, tapg;
    logic [1:0] tap3;
    logic       tap0;

    logic v4, v3, vg, v0;
    logic [W-1:0] d4, d3, dg, d0;
    logic [2:0] c4, cg;
    logic [1:0] c3;
    logic       c0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bsg_dff_chain_tap_en #(.width_p(W), .max_stages_p(4), .gate_data_p(1'b0)) u4 (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .flush_i(flush_i), .v_i(v_i),
        .data_i(data_i), .tap_i(tap4), .v_o(v4), .data_o(d4), .cnt_o(c4));
    bsg_dff_chain_tap_en #(.width_p(W), .max_stages_p(3), .gate_data_p(1'b0)) u3 (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .flush_i(flush_i), .v_i(v_i),
        .data_i(data_i), .tap_i(tap3), .v_o(v3), .data_o(d3), .cnt_o(c3));
    bsg_dff_chain_tap_en #(.width_p(W), .max_stages_p(4), .gate_data_p(1'b1)) ug (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .flush_i(flush_i), .v_i(v_i),
        .data_i(data_i), .tap_i(tapg), .v_o(vg), .data_o(dg), .cnt_o(cg));
    bsg_dff_chain_tap_en #(.width_p(W), .max_stages_p(0), .gate_data_p(1'b0)) u0 (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .flush_i(flush_i), .v_i(v_i),
        .data_i(data_i), .tap_i(tap0), .v_o(v0), .data_o(d0), .cnt_o(c0));

    // Reference model: per-instance stage contents, index 1..depth.
    logic         mv [0:3][1:4];
    logic [W-1:0] md [0:3][1:4];
    int dep [0:3] = '{4, 3, 4, 0};
    bit gt  [0:3] = '{1'b0, 1'b0, 1'b1, 1'b0};

    typedef struct {
        logic en, flush, v;
        logic [W-1:0] data;
        logic [2:0] tap;
        logic ev;
        logic [W-1:0] ed;
        logic [2:0] ec;
    } vec_t;
    vec_t tbl [0:6];

    function automatic void model_clear();
        for (int i = 0; i < 4; i++)
            for (int k = 1; k <= 4; k++) begin
                mv[i][k] = 1'b0;
                md[i][k] = '0;
            end
    endfunction

    function automatic void model_edge();
        logic sv;
        logic [W-1:0] sd;
        if (reset_i) begin
            model_clear();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (flush_i) begin
                for (int k = 1; k <= dep[i]; k++) mv[i][k] = 1'b0;
            end else if (en_i) begin
                for (int k = dep[i]; k >= 1; k--) begin
                    sv = (k == 1) ? v_i : mv[i][k-1];
                    sd = (k == 1) ? data_i : md[i][k-1];
                    mv[i][k] = sv;
                    if (!gt[i] || sv) md[i][k] = sd;
                end
            end
        end
    endfunction

    function automatic int sel_tap(int i);
        int t;
        case (i)
            0: t = int'(tap4);
            1: t = int'(tap3);
            2: t = int'(tapg);
            default: t = int'(tap0);
        endcase
        return (t > dep[i]) ? dep[i] : t;
    endfunction

    function automatic logic [31:0] exp_v(int i);
        int t = sel_tap(i);
        return (t == 0) ? 32'(v_i) : 32'(mv[i][t]);
    endfunction

    function automatic logic [31:0] exp_d(int i);
        int t = sel_tap(i);
        return (t == 0) ? 32'(data_i) : 32'(md[i][t]);
    endfunction

    function automatic logic [31:0] exp_c(int i);
        int n = 0;
        for (int k = 1; k <= dep[i]; k++) n += int'(mv[i][k]);
        return 32'(n);
    endfunction

    function automatic logic [31:0] act_v(int i);
        case (i)
            0: return 32'(v4);
            1: return 32'(v3);
            2: return 32'(vg);
            default: return 32'(v0);
        endcase
    endfunction

    function automatic logic [31:0] act_d(int i);
        case (i)
            0: return 32'(d4);
            1: return 32'(d3);
            2: return 32'(dg);
            default: return 32'(d0);
        endcase
    endfunction

    function automatic logic [31:0] act_c(int i);
        case (i)
            0: return 32'(c4);
            1: return 32'(c3);
            2: return 32'(cg);
            default: return 32'(c0);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s u%0d v_o", tag, i), act_v(i), exp_v(i));
            chk($sformatf("%s u%0d data_o", tag, i), act_d(i), exp_d(i));
            chk($sformatf("%s u%0d cnt_o", tag, i), act_c(i), exp_c(i));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        logic [W-1:0] sweep_exp [0:3];

        // en, flush, v, data, tap, exp v, exp data, exp cnt  (D=4 instance)
        tbl[0] = '{1'b1, 1'b0, 1'b1, 27'h1, 3'd3, 1'b0, 27'h0, 3'd1};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 27'h2, 3'd3, 1'b0, 27'h0, 3'd2};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 27'h3, 3'd3, 1'b1, 27'h1, 3'd3};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 27'h0, 3'd3, 1'b1, 27'h2, 3'd3};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 27'h0, 3'd3, 1'b1, 27'h3, 3'd2};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 27'h0, 3'd3, 1'b0, 27'h0, 3'd1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 27'h0, 3'd3, 1'b0, 27'h0, 3'd0};

        reset_i = 1'b1; en_i = 1'b0; flush_i = 1'b0; v_i = 1'b0; data_i = '0;
        tap4 = 3'd4; tap3 = 2'd3; tapg = 3'd4; tap0 = 1'b0;
        model_clear();
        step();
        step();
        chk("reset v_o", 32'(v4), 32'd0);
        chk("reset data_o", 32'(d4), 32'd0);
        chk("reset cnt_o", 32'(c4), 32'd0);
        check_model("reset");
        reset_i = 1'b0;

        // Fixed delay of three through the table.
        for (int r = 0; r < 7; r++) begin
            en_i = tbl[r].en; flush_i = tbl[r].flush; v_i = tbl[r].v;
            data_i = tbl[r].data; tap4 = tbl[r].tap;
            step();
            chk($sformatf("tbl%0d v_o", r), 32'(v4), 32'(tbl[r].ev));
            chk($sformatf("tbl%0d data_o", r), 32'(d4), 32'(tbl[r].ed));
            chk($sformatf("tbl%0d cnt_o", r), 32'(c4), 32'(tbl[r].ec));
            check_model($sformatf("tbl%0d", r));
        end

        // Stall: word must survive five held cycles without advancing.
        tap4 = 3'd2; en_i = 1'b1; v_i = 1'b1; data_i = 27'hA;
        step();
        en_i = 1'b0; v_i = 1'b0; data_i = '0;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("stall v_o", 32'(v4), 32'd0);
            chk("stall cnt_o", 32'(c4), 32'd1);
        end
        en_i = 1'b1;
        step();
        chk("stall release v_o", 32'(v4), 32'd1);
        chk("stall release data_o", 32'(d4), 32'hA);
        check_model("stall");

        // Fill all stages, then flush with enable and valid input high.
        for (int j = 0; j < 4; j++) begin
            v_i = 1'b1; data_i = W'(32'h10 + j);
            step();
        end
        chk("fill cnt_o", 32'(c4), 32'd4);
        flush_i = 1'b1; en_i = 1'b1; v_i = 1'b1; data_i = 27'h99;
        step();
        flush_i = 1'b0; en_i = 1'b0; v_i = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tap4 = 3'(t);
            #1;
            chk($sformatf("flush tap%0d v_o", t), 32'(v4), 32'd0);
            chk("flush cnt_o", 32'(c4), 32'd0);
            check_model("flush");
        end

        // Tap sweep on D=3, clamp on D=4.
        en_i = 1'b1;
        v_i = 1'b1; data_i = 27'h11; step();
        v_i = 1'b1; data_i = 27'h22; step();
        v_i = 1'b1; data_i = 27'h33; step();
        en_i = 1'b0; v_i = 1'b1; data_i = 27'h44;
        sweep_exp[0] = 27'h44; sweep_exp[1] = 27'h33;
        sweep_exp[2] = 27'h22; sweep_exp[3] = 27'h11;
        for (int t = 0; t < 4; t++) begin
            tap3 = 2'(t);
            #1;
            chk($sformatf("sweep tap%0d v_o", t), 32'(v3), 32'd1);
            chk($sformatf("sweep tap%0d data_o", t), 32'(d3), 32'(sweep_exp[t]));
        end
        tap4 = 3'd7;
        #1;
        chk("clamp7 v_o", 32'(v4), 32'd0);
        chk("clamp7 data_o", 32'(d4), 32'h13);
        check_model("clamp7");
        en_i = 1'b1;
        step();
        tap4 = 3'd7; #1;
        chk("clamp7b v_o", 32'(v4), 32'd1);
        chk("clamp7b data_o", 32'(d4), 32'h11);
        tap4 = 3'd4; #1;
        check_model("clamp4");

        // Data gating: bubble behind 0x5 keeps 0x5 in the gated chain.
        en_i = 1'b1; v_i = 1'b1; data_i = 27'h5; step();
        v_i = 1'b0; data_i = 27'hFFF; step();
        en_i = 1'b0; tapg = 3'd1; tap4 = 3'd1;
        #1;
        chk("gate bubble v_o", 32'(vg), 32'd0);
        chk("gate bubble data_o", 32'(dg), 32'h5);
        chk("nogate bubble data_o", 32'(d4), 32'hFFF);
        tapg = 3'd2; #1;
        chk("gate word v_o", 32'(vg), 32'd1);
        chk("gate word data_o", 32'(dg), 32'h5);
        check_model("gate");

        // Asynchronous reset while data is in flight.
        tap4 = 3'd4; en_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            v_i = 1'b1; data_i = W'(32'h101 + j);
            step();
        end
        chk("inflight v_o", 32'(v4), 32'd1);
        chk("inflight data_o", 32'(d4), 32'h101);
        v_i = 1'b1; data_i = 27'h105;
        @(negedge clk);
        #1;
        reset_i = 1'b1;
        model_clear();
        #1;
        chk("async reset v_o", 32'(v4), 32'd0);
        chk("async reset data_o", 32'(d4), 32'd0);
        chk("async reset cnt_o", 32'(c4), 32'd0);
        check_model("async reset");
        step();
        reset_i = 1'b0; en_i = 1'b0; v_i = 1'b1; data_i = 27'h77;
        step();
        chk("post reset stall cnt_o", 32'(c4), 32'd0);
        en_i = 1'b1;
        step();
        en_i = 1'b0;
        tap4 = 3'd1; #1;
        chk("post reset capture cnt_o", 32'(c4), 32'd1);
        chk("post reset capture data_o", 32'(d4), 32'h77);
        check_model("post reset");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            en_i    = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 19) == 0);
            v_i     = 1'($urandom);
            data_i  = W'($urandom);
            tap4    = 3'($urandom);
            tap3    = 2'($urandom);
            tapg    = 3'($urandom);
            tap0    = 1'($urandom);
            #1;
            check_model("rand");
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
